// File: rtl/vec_regfile_burst.sv
// Parametrised vector register file: LANES-wide masked writes, combinational direct reads,
// and a valid/ready burst-read sequencer streaming VL elements in LANES-wide registered beats.
module vec_regfile_burst #(
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned NREG   = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_base,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*ELEM_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [LANES*ELEM_W-1:0] rd_data,
  input  logic                    bq_valid,
  output logic                    bq_ready,
  input  logic [AW-1:0]           bq_base,
  input  logic [AW:0]             bq_vl,
  output logic                    bo_valid,
  input  logic                    bo_ready,
  output logic [LANES*ELEM_W-1:0] bo_data,
  output logic [LANES-1:0]        bo_mask,
  output logic                    bo_last
);

  localparam int unsigned DW = LANES * ELEM_W;
  // Truncation to AW bits gives the mod-NREG pointer step for free (NREG is a power of 2).
  localparam logic [AW-1:0] LanesA = AW'(LANES);
  localparam logic [AW:0]   LanesR = (AW + 1)'(LANES);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  logic [ELEM_W-1:0] mem_q [NREG];
  logic [ELEM_W-1:0] mem_d [NREG];

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      rem_q, rem_d;
  logic             bo_valid_q, bo_valid_d;
  logic [DW-1:0]    bo_data_q, bo_data_d;
  logic [LANES-1:0] bo_mask_q, bo_mask_d;
  logic             bo_last_q, bo_last_d;

  logic             load;
  logic [AW-1:0]    ld_base;
  logic [AW:0]      ld_rem;
  logic [DW-1:0]    beat_data;
  logic [LANES-1:0] beat_mask;

  // Array write path
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wr_mask[i]) begin
          mem_d[wr_base + AW'(i)] = wr_data[i*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  // Direct read: no bypass, so a write shows up only after its edge
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      rd_data[i*ELEM_W +: ELEM_W] = mem_q[rd_addr + AW'(i)];
    end
  end

  // Sequencer next state and beat-load selection
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    load    = 1'b0;
    ld_base = ptr_q;
    ld_rem  = rem_q;
    unique case (state_q)
      StIdle: begin
        // A zero-length request is accepted here and simply dropped
        if (bq_valid && (bq_vl != '0)) begin
          state_d = StStream;
          load    = 1'b1;
          ld_base = bq_base;
          ld_rem  = bq_vl;
          ptr_d   = bq_base + LanesA;
          rem_d   = bq_vl;
        end
      end
      StStream: begin
        if (bo_ready) begin
          if (bo_last_q) begin
            state_d = StIdle;
          end else begin
            load    = 1'b1;
            ld_base = ptr_q;
            ld_rem  = rem_q - LanesR;
            ptr_d   = ptr_q + LanesA;
            rem_d   = rem_q - LanesR;
          end
        end
      end
    endcase
  end

  // Beat is read from mem_q, so a same-edge write to the same element is not captured
  always_comb begin
    beat_data = '0;
    beat_mask = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if ((AW + 1)'(i) < ld_rem) begin
        beat_mask[i]                  = 1'b1;
        beat_data[i*ELEM_W +: ELEM_W] = mem_q[ld_base + AW'(i)];
      end
    end
  end

  always_comb begin
    bo_valid_d = (state_d == StStream);
    bo_data_d  = bo_data_q;
    bo_mask_d  = bo_mask_q;
    bo_last_d  = bo_last_q;
    if (load) begin
      bo_data_d = beat_data;
      bo_mask_d = beat_mask;
      bo_last_d = (ld_rem <= LanesR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rem_q      <= '0;
      bo_valid_q <= 1'b0;
      bo_data_q  <= '0;
      bo_mask_q  <= '0;
      bo_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      bo_valid_q <= bo_valid_d;
      bo_data_q  <= bo_data_d;
      bo_mask_q  <= bo_mask_d;
      bo_last_q  <= bo_last_d;
    end
  end

  assign bq_ready = (state_q == StIdle);
  assign bo_valid = bo_valid_q;
  assign bo_data  = bo_data_q;
  assign bo_mask  = bo_mask_q;
  assign bo_last  = bo_last_q;

endmodule

// File: tb/tb_vec_regfile_burst.sv
// Bench for vec_regfile_burst (ELEM_W=32, NREG=8, LANES=2): table-driven write/read vectors
// plus a beat scoreboard for bursts, backpressure, collisions, zero length and async reset.
module tb_vec_regfile_burst;

  localparam int unsigned EW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned LN = 2;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_base;
  logic [LN-1:0] wr_mask;
  logic [63:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic          bq_valid;
  logic          bq_ready;
  logic [AW-1:0] bq_base;
  logic [AW:0]   bq_vl;
  logic          bo_valid;
  logic          bo_ready;
  logic [63:0]   bo_data;
  logic [LN-1:0] bo_mask;
  logic          bo_last;

  vec_regfile_burst #(
    .ELEM_W(EW),
    .NREG  (NR),
    .LANES (LN),
    .AW    (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_base (wr_base),
    .wr_mask (wr_mask),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .bq_valid(bq_valid),
    .bq_ready(bq_ready),
    .bq_base (bq_base),
    .bq_vl   (bq_vl),
    .bo_valid(bo_valid),
    .bo_ready(bo_ready),
    .bo_data (bo_data),
    .bo_mask (bo_mask),
    .bo_last (bo_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mask;
    logic        last;
  } beat_t;

  typedef struct {
    logic        we;
    logic [2:0]  base;
    logic [1:0]  mask;
    logic [63:0] wdata;
    logic [2:0]  raddr;
    logic [63:0] exp_rd;
  } vec_t;

  localparam logic [31:0] VA = 32'hAAAA_0001;
  localparam logic [31:0] VB = 32'hBBBB_0002;
  localparam logic [31:0] VC = 32'hCCCC_0003;
  localparam logic [31:0] VD = 32'hDDDD_0004;
  localparam logic [31:0] VE = 32'hEEEE_0005;
  localparam logic [31:0] VF = 32'hFFFF_0006;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [NR];
  beat_t       exp_q [$];
  vec_t        vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input int base, input logic [1:0] mask, input logic [63:0] data);
    wr_en   = 1'b1;
    wr_base = AW'(base);
    wr_mask = mask;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (mask[0]) model[base % NR] = data[31:0];
    if (mask[1]) model[(base + 1) % NR] = data[63:32];
  endtask

  // Expected beats are derived from the model at request time
  task automatic push_burst(input int base, input int vl);
    int    rem;
    int    p;
    beat_t b;
    rem = vl;
    p   = base;
    while (rem > 0) begin
      b.data = '0;
      b.mask = '0;
      if (rem > 0) begin b.data[31:0]  = model[p % NR];       b.mask[0] = 1'b1; end
      if (rem > 1) begin b.data[63:32] = model[(p + 1) % NR]; b.mask[1] = 1'b1; end
      b.last = (rem <= 2);
      exp_q.push_back(b);
      p   = (p + 2) % NR;
      rem = (rem > 2) ? rem - 2 : 0;
    end
  endtask

  task automatic cmp_beat(input string tag);
    beat_t e;
    e = exp_q.pop_front();
    chk({tag, "_data"}, bo_data, e.data);
    chk({tag, "_mask"}, 64'(bo_mask), 64'(e.mask));
    chk({tag, "_last"}, 64'(bo_last), 64'(e.last));
  endtask

  // Consumes queued beats with bo_ready high; returns one cycle after the final handshake
  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      if (bo_valid) cmp_beat(tag);
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic request(input int base, input int vl);
    bq_valid = 1'b1;
    bq_base  = AW'(base);
    bq_vl    = (AW + 1)'(vl);
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_base  = '0;
    wr_mask  = '0;
    wr_data  = '0;
    rd_addr  = 3'd3;
    bq_valid = 1'b0;
    bq_base  = '0;
    bq_vl    = '0;
    bo_ready = 1'b1;
    for (int i = 0; i < int'(NR); i++) model[i] = '0;

    vecs[0] = '{we: 1'b0, base: 3'd0, mask: 2'b00, wdata: 64'd0,      raddr: 3'd3, exp_rd: 64'd0};
    vecs[1] = '{we: 1'b1, base: 3'd3, mask: 2'b11, wdata: {VB, VA},   raddr: 3'd3, exp_rd: {VB, VA}};
    vecs[2] = '{we: 1'b0, base: 3'd0, mask: 2'b00, wdata: 64'd0,      raddr: 3'd4, exp_rd: {32'd0, VB}};
    vecs[3] = '{we: 1'b1, base: 3'd7, mask: 2'b11, wdata: {VD, VC},   raddr: 3'd7, exp_rd: {VD, VC}};
    vecs[4] = '{we: 1'b1, base: 3'd0, mask: 2'b10, wdata: {VF, VE},   raddr: 3'd0, exp_rd: {VF, VD}};
    vecs[5] = '{we: 1'b0, base: 3'd0, mask: 2'b00, wdata: 64'd0,      raddr: 3'd2, exp_rd: {VA, 32'd0}};

    #3;
    chk("rst_bq_ready", 64'(bq_ready), 64'd1);
    chk("rst_bo_valid", 64'(bo_valid), 64'd0);
    chk("rst_bo_data", bo_data, 64'd0);
    chk("rst_bo_mask_last", {62'd0, bo_mask[0] | bo_mask[1], bo_last}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[k]) begin
      if (vecs[k].we) do_write(int'(vecs[k].base), vecs[k].mask, vecs[k].wdata);
      rd_addr = vecs[k].raddr;
      #1;
      chk($sformatf("vec%0d_rd", k), rd_data, vecs[k].exp_rd);
    end

    // Preload reg[k] = k
    for (int k = 0; k < int'(NR); k += 2) do_write(k, 2'b11, {32'(k + 1), 32'(k)});
    rd_addr = 3'd6;
    #1;
    chk("preload_rd6", rd_data, {32'd7, 32'd6});

    // Odd-length burst with wrap
    @(posedge clk);
    #1;
    request(6, 5);
    chk("odd_bq_ready", 64'(bq_ready), 64'd1);
    push_burst(6, 5);
    @(posedge clk);
    #1;
    bq_valid = 1'b0;
    chk("odd_first_valid", 64'(bo_valid), 64'd1);
    chk("odd_busy", 64'(bq_ready), 64'd0);
    drain("odd", 10);
    chk("odd_end_valid", 64'(bo_valid), 64'd0);

    // Backpressure hold with writes to the held element, then a load-edge collision
    request(0, 4);
    push_burst(0, 4);
    bo_ready = 1'b0;
    @(posedge clk);
    #1;
    bq_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk($sformatf("hold%0d_valid", h), 64'(bo_valid), 64'd1);
      chk($sformatf("hold%0d_data", h), bo_data, exp_q[0].data);
      if (h == 0) do_write(0, 2'b01, {32'd0, 32'h55});
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("hold_final_data", bo_data, exp_q[0].data);
    cmp_beat("bp0");
    bo_ready = 1'b1;
    do_write(2, 2'b01, {32'd0, 32'h66});
    drain("coll", 10);
    chk("coll_end_valid", 64'(bo_valid), 64'd0);

    request(0, 3);
    push_burst(0, 3);
    @(posedge clk);
    #1;
    bq_valid = 1'b0;
    drain("newval", 10);

    // Zero-length request
    request(3, 0);
    chk("zero_bq_ready", 64'(bq_ready), 64'd1);
    @(posedge clk);
    #1;
    bq_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("zero_no_valid%0d", c), 64'(bo_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // Request held during STREAM is taken in the first IDLE cycle
    request(4, 6);
    push_burst(4, 6);
    @(posedge clk);
    #1;
    request(1, 3);
    push_burst(1, 3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy%0d_bq_ready", k), 64'(bq_ready), (k == 3) ? 64'd1 : 64'd0);
      if (k == 3) chk("busy_bubble", 64'(bo_valid), 64'd0);
      else if (bo_valid) cmp_beat($sformatf("busy%0d", k));
      else chk($sformatf("busy%0d_valid", k), 64'(bo_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    bq_valid = 1'b0;
    chk("queued_first_valid", 64'(bo_valid), 64'd1);
    drain("queued", 10);
    chk("queued_end_valid", 64'(bo_valid), 64'd0);

    // Asynchronous reset during the second beat
    request(0, 8);
    push_burst(0, 8);
    @(posedge clk);
    #1;
    bq_valid = 1'b0;
    cmp_beat("rst_b0");
    @(posedge clk);
    #1;
    chk("rst_b1_valid", 64'(bo_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    rd_addr = 3'd0;
    chk("arst_bo_valid", 64'(bo_valid), 64'd0);
    chk("arst_bo_data", bo_data, 64'd0);
    chk("arst_bq_ready", 64'(bq_ready), 64'd1);
    #0.5;
    chk("arst_rd0", rd_data, 64'd0);
    rd_addr = 3'd6;
    #0.5;
    chk("arst_rd6", rd_data, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    @(posedge clk);
    #1;
    chk("post_rst_bq_ready", 64'(bq_ready), 64'd1);
    chk("post_rst_bo_valid", 64'(bo_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
